// File: rtl/sound_sequencer.sv
// Note-queue controller for SoundGenerator: buffers (duration, half-period) notes,
// plays them back-to-back, times rests and inter-note gaps, and supports abort.
module sound_sequencer #(
   parameter int CLOCK_HZ   = 10_000_000,
   parameter int FIFO_DEPTH = 8,
   parameter int GAP_MS     = 20
) (
   input  logic                          Clock,
   input  logic                          Reset,
   input  logic                          Write_i,
   input  logic [15:0]                   Duration_ms_i,
   input  logic [15:0]                   HalfPeriod_us_i,
   input  logic                          Abort_i,
   output logic                          Full_o,
   output logic                          Empty_o,
   output logic [$clog2(FIFO_DEPTH):0]   Count_o,
   output logic                          GenRequest_o,
   output logic [15:0]                   GenDuration_ms_o,
   output logic [15:0]                   GenHalfPeriod_us_o,
   input  logic                          GenBusy_i,
   input  logic                          GenDone_i,
   output logic                          Busy_o,
   output logic                          Done_o
);

   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int PRESC_TC = CLOCK_HZ / 1000 - 1;
   localparam int PRESC_W  = (PRESC_TC > 0) ? $clog2(PRESC_TC + 1) : 1;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_TC);
   localparam logic [CNT_W-1:0]   DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [15:0]        GAP_LOAD   = 16'(GAP_MS);
   localparam bit                 GAP_EN     = (GAP_MS != 0);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECIDE = 3'd2;
   localparam logic [2:0] S_ISSUE  = 3'd3;
   localparam logic [2:0] S_PLAY   = 3'd4;
   localparam logic [2:0] S_REST   = 3'd5;
   localparam logic [2:0] S_GAP    = 3'd6;

   logic [2:0]         r_state;
   logic [31:0]        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [15:0]        r_note_dur;
   logic [15:0]        r_note_hp;
   logic [15:0]        r_gen_dur;
   logic [15:0]        r_gen_hp;
   logic [15:0]        r_remain;
   logic [PRESC_W-1:0] r_presc;
   logic               r_done;

   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic               w_tick;
   logic               w_timer_last;
   logic               w_abort_silence;
   logic [2:0]         w_next_state;
   logic               w_set_done;
   logic               w_enter_timer;
   logic [15:0]        w_timer_load;
   logic               w_load_gen;
   logic               w_note_end;
   logic               w_gap_end;

   assign w_full  = (r_count == DEPTH_CNT);
   assign w_empty = (r_count == '0);

   // A write while full is lost even if the same cycle pops; abort drops writes too.
   assign w_push = Write_i && !w_full && !Abort_i;
   assign w_pop  = (r_state == S_FETCH) && !Abort_i;

   assign w_tick       = (r_presc == PRESC_LAST);
   assign w_timer_last = w_tick && (r_remain == 16'd1);

   assign w_abort_silence = Abort_i &&
                            ((r_state == S_ISSUE) || (r_state == S_PLAY) || GenBusy_i);

   always_comb begin
      w_next_state  = r_state;
      w_set_done    = 1'b0;
      w_enter_timer = 1'b0;
      w_timer_load  = GAP_LOAD;
      w_load_gen    = 1'b0;
      w_note_end    = 1'b0;
      w_gap_end     = 1'b0;
      case (r_state)
         S_IDLE:   if (!w_empty) w_next_state = S_FETCH;
         S_FETCH:  w_next_state = S_DECIDE;
         S_DECIDE: begin
            if (r_note_dur == 16'd0) begin
               w_next_state = w_empty ? S_IDLE : S_FETCH;
            end else if (r_note_hp == 16'd0) begin
               w_next_state  = S_REST;
               w_enter_timer = 1'b1;
               w_timer_load  = r_note_dur;
            end else begin
               w_next_state = S_ISSUE;
               w_load_gen   = 1'b1;
            end
         end
         S_ISSUE:  w_next_state = S_PLAY;
         S_PLAY:   if (GenDone_i) w_note_end = 1'b1;
         S_REST:   if (w_timer_last) w_note_end = 1'b1;
         S_GAP:    if (w_timer_last) w_gap_end = 1'b1;
         default:  w_next_state = S_IDLE;
      endcase

      // Every played note or rest is followed by the gap unless the gap is disabled.
      if (w_note_end && GAP_EN) begin
         w_next_state  = S_GAP;
         w_enter_timer = 1'b1;
         w_timer_load  = GAP_LOAD;
      end else if (w_note_end || w_gap_end) begin
         w_next_state = w_empty ? S_IDLE : S_FETCH;
         w_set_done   = w_empty;
      end

      if (Abort_i) begin
         w_next_state  = S_IDLE;
         w_set_done    = 1'b0;
         w_enter_timer = 1'b0;
         w_load_gen    = 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state   <= S_IDLE;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_presc   <= '0;
         r_remain  <= '0;
         r_done    <= 1'b0;
         r_gen_dur <= '0;
         r_gen_hp  <= '0;
      end else begin
         r_state <= w_next_state;
         r_done  <= w_set_done;

         if (Abort_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
         end

         // The ms prescaler only runs while timing silence and restarts on each entry.
         if (w_enter_timer) begin
            r_presc  <= '0;
            r_remain <= w_timer_load;
         end else if (((r_state == S_REST) || (r_state == S_GAP)) && !Abort_i) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) r_remain <= r_remain - 16'd1;
         end else begin
            r_presc <= '0;
         end

         if (w_abort_silence) begin
            r_gen_dur <= 16'd0;
            r_gen_hp  <= 16'd1;
         end else if (w_load_gen) begin
            r_gen_dur <= r_note_dur;
            r_gen_hp  <= r_note_hp;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (w_push) r_mem[r_wr_ptr] <= {Duration_ms_i, HalfPeriod_us_i};
      if (w_pop)  {r_note_dur, r_note_hp} <= r_mem[r_rd_ptr];
   end

   assign Full_o             = w_full;
   assign Empty_o            = w_empty;
   assign Count_o            = r_count;
   assign Busy_o             = (r_state != S_IDLE);
   assign Done_o             = r_done;
   assign GenRequest_o       = (r_state == S_ISSUE) || w_abort_silence;
   assign GenDuration_ms_o   = w_abort_silence ? 16'd0 : r_gen_dur;
   assign GenHalfPeriod_us_o = w_abort_silence ? 16'd1 : r_gen_hp;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer: a queue/countdown model checked every cycle,
// plus hand-computed latencies and values for each scenario.
module tb_sound_sequencer;

   localparam int CLOCK_HZ = 1_000_000;
   localparam int DEPTH    = 8;
   localparam int GAP_MS   = 2;
   localparam int K        = CLOCK_HZ / 1000;
   localparam int GAP_CYC  = GAP_MS * K;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        Write_i = 1'b0;
   logic [15:0] Duration_ms_i = 16'd0;
   logic [15:0] HalfPeriod_us_i = 16'd0;
   logic        Abort_i = 1'b0;
   logic        GenBusy_i = 1'b0;
   logic        GenDone_i = 1'b0;
   logic        Full_o, Empty_o, GenRequest_o, Busy_o, Done_o;
   logic [3:0]  Count_o;
   logic [15:0] GenDuration_ms_o, GenHalfPeriod_us_o;

   sound_sequencer #(.CLOCK_HZ(CLOCK_HZ), .FIFO_DEPTH(DEPTH), .GAP_MS(GAP_MS)) dut (
      .Clock(Clock), .Reset(Reset), .Write_i(Write_i), .Duration_ms_i(Duration_ms_i),
      .HalfPeriod_us_i(HalfPeriod_us_i), .Abort_i(Abort_i), .Full_o(Full_o),
      .Empty_o(Empty_o), .Count_o(Count_o), .GenRequest_o(GenRequest_o),
      .GenDuration_ms_o(GenDuration_ms_o), .GenHalfPeriod_us_o(GenHalfPeriod_us_o),
      .GenBusy_i(GenBusy_i), .GenDone_i(GenDone_i), .Busy_o(Busy_o), .Done_o(Done_o)
   );

   always #5 Clock = ~Clock;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int req_cnt = 0;
   int done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge Clock);
      cyc++;
   end

   // Model: queue of pending notes; playback as activities measured in whole cycles.
   localparam int M_IDLE = 0, M_FETCH = 1, M_DECIDE = 2, M_REQ = 3, M_WAIT = 4, M_QUIET = 5;
   int          m_mode = M_IDLE;
   int          m_quiet = 0;
   logic [31:0] mq[$];
   logic [15:0] m_dur = 16'd0, m_hp = 16'd0, m_gdur = 16'd0, m_ghp = 16'd0;
   bit          m_done = 1'b0;

   task automatic model_step();
      int pre_size;
      bit take, fin;
      pre_size = mq.size();
      take = 1'b0;
      fin = 1'b0;
      m_done = 1'b0;
      if (Abort_i) begin
         if (m_mode == M_REQ || m_mode == M_WAIT || GenBusy_i) begin
            m_gdur = 16'd0;
            m_ghp = 16'd1;
         end
         mq.delete();
         m_mode = M_IDLE;
         return;
      end
      case (m_mode)
         M_IDLE:  if (pre_size != 0) m_mode = M_FETCH;
         M_FETCH: begin
            {m_dur, m_hp} = mq[0];
            take = 1'b1;
            m_mode = M_DECIDE;
         end
         M_DECIDE: begin
            if (m_dur == 16'd0) m_mode = (pre_size == 0) ? M_IDLE : M_FETCH;
            else if (m_hp == 16'd0) begin
               m_mode = M_QUIET;
               m_quiet = int'(m_dur) * K + GAP_CYC;
            end else begin
               m_mode = M_REQ;
               m_gdur = m_dur;
               m_ghp = m_hp;
            end
         end
         M_REQ:  m_mode = M_WAIT;
         M_WAIT: begin
            if (GenDone_i) begin
               if (GAP_CYC == 0) fin = 1'b1;
               else begin
                  m_mode = M_QUIET;
                  m_quiet = GAP_CYC;
               end
            end
         end
         M_QUIET: begin
            if (m_quiet == 1) fin = 1'b1;
            else m_quiet--;
         end
         default: m_mode = M_IDLE;
      endcase
      if (fin) begin
         if (pre_size == 0) begin
            m_mode = M_IDLE;
            m_done = 1'b1;
         end else m_mode = M_FETCH;
      end
      if (take) void'(mq.pop_front());
      if (Write_i && pre_size < DEPTH) mq.push_back({Duration_ms_i, HalfPeriod_us_i});
   endtask

   initial forever begin
      @(posedge Clock or negedge Reset);
      if (!Reset) begin
         mq.delete();
         m_mode = M_IDLE;
         m_quiet = 0;
         m_done = 1'b0;
         m_gdur = 16'd0;
         m_ghp = 16'd0;
      end else model_step();
   end

   // Per-cycle comparison against the model, plus request/done bookkeeping.
   initial begin
      bit ab;
      @(posedge Clock);
      forever begin
         @(negedge Clock);
         ab = Abort_i && (m_mode == M_REQ || m_mode == M_WAIT || GenBusy_i);
         chk("Count_o", 32'(Count_o), 32'(mq.size()));
         chk("Full_o", 32'(Full_o), 32'(mq.size() == DEPTH));
         chk("Empty_o", 32'(Empty_o), 32'(mq.size() == 0));
         chk("Busy_o", 32'(Busy_o), 32'(m_mode != M_IDLE));
         chk("Done_o", 32'(Done_o), 32'(m_done));
         chk("GenRequest_o", 32'(GenRequest_o), 32'((m_mode == M_REQ) || ab));
         chk("GenDuration_ms_o", 32'(GenDuration_ms_o), ab ? 32'd0 : 32'(m_gdur));
         chk("GenHalfPeriod_us_o", 32'(GenHalfPeriod_us_o), ab ? 32'd1 : 32'(m_ghp));
         if (GenRequest_o) req_cnt++;
         if (Done_o) done_cnt++;
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic write_note(input logic [15:0] d, input logic [15:0] h);
      Write_i = 1'b1;
      Duration_ms_i = d;
      HalfPeriod_us_i = h;
      tick();
      Write_i = 1'b0;
   endtask

   task automatic wait_req(input int limit, output int c);
      c = -1;
      for (int i = 0; i < limit; i++) begin
         if (GenRequest_o) begin
            c = cyc;
            break;
         end
         tick();
      end
      n_chk++;
      if (c < 0) begin
         n_err++;
         $display("FAIL wait_req: no GenRequest_o within %0d cycles", limit);
      end
   endtask

   task automatic wait_done(input int limit, output int c);
      c = -1;
      for (int i = 0; i < limit; i++) begin
         if (Done_o) begin
            c = cyc;
            break;
         end
         tick();
      end
      n_chk++;
      if (c < 0) begin
         n_err++;
         $display("FAIL wait_done: no Done_o within %0d cycles", limit);
      end
   endtask

   // Generator stub: busy from the cycle after the request, Done pulse after lat cycles.
   task automatic gen_play(input int lat, output int p);
      tick();
      GenBusy_i = 1'b1;
      repeat (lat) tick();
      GenDone_i = 1'b1;
      GenBusy_i = 1'b0;
      p = cyc;
      tick();
      GenDone_i = 1'b0;
   endtask

   initial begin
      int w, c, p, d, rc0, dc0;
      // Reset state
      repeat (3) tick();
      chk("rst Empty_o", 32'(Empty_o), 32'd1);
      chk("rst Count_o", 32'(Count_o), 32'd0);
      chk("rst Busy_o", 32'(Busy_o), 32'd0);
      chk("rst GenRequest_o", 32'(GenRequest_o), 32'd0);
      chk("rst GenDuration_ms_o", 32'(GenDuration_ms_o), 32'd0);
      Reset = 1'b1;
      tick();

      // Single tone 5 ms / 250 us
      w = cyc;
      write_note(16'd5, 16'd250);
      wait_req(20, c);
      chk("t1 request latency", 32'(c - w), 32'd4);
      chk("t1 request duration", 32'(GenDuration_ms_o), 32'd5);
      chk("t1 request halfperiod", 32'(GenHalfPeriod_us_o), 32'd250);
      gen_play(10, p);
      wait_done(GAP_CYC + 20, d);
      chk("t1 done after gen done", 32'(d - p), 32'd2001);
      chk("t1 busy low at done", 32'(Busy_o), 32'd0);
      tick();
      chk("t1 done one cycle", 32'(Done_o), 32'd0);

      // Rest 3 ms then tone 1 ms / 100 us
      rc0 = req_cnt;
      dc0 = done_cnt;
      w = cyc;
      write_note(16'd3, 16'd0);
      write_note(16'd1, 16'd100);
      wait_req(6000, c);
      chk("t2 no request for rest", 32'(req_cnt - rc0), 32'd0);
      chk("t2 rest+gap latency", 32'(c - w), 32'd5006);
      chk("t2 request halfperiod", 32'(GenHalfPeriod_us_o), 32'd100);
      gen_play(3, p);
      wait_done(GAP_CYC + 20, d);
      tick();
      chk("t2 single done", 32'(done_cnt - dc0), 32'd1);

      // Stall in PLAY, fill the queue, overflow, then drain
      rc0 = req_cnt;
      write_note(16'd1, 16'd300);
      wait_req(20, c);
      tick();
      GenBusy_i = 1'b1;
      for (int i = 0; i < 9; i++) write_note(16'd1, 16'(10 + i));
      chk("t3 Full_o", 32'(Full_o), 32'd1);
      chk("t3 Count_o", 32'(Count_o), 32'd8);
      GenDone_i = 1'b1;
      GenBusy_i = 1'b0;
      p = cyc;
      tick();
      GenDone_i = 1'b0;
      repeat (2000) tick();
      Write_i = 1'b1;
      Duration_ms_i = 16'd7;
      HalfPeriod_us_i = 16'd7;
      tick();
      Write_i = 1'b0;
      chk("t3 write while full with pop", 32'(Count_o), 32'd7);
      for (int i = 0; i < 8; i++) begin
         wait_req(GAP_CYC + 20, c);
         chk("t3 drain order", 32'(GenHalfPeriod_us_o), 32'(10 + i));
         gen_play(2, p);
      end
      wait_done(GAP_CYC + 20, d);
      tick();
      chk("t3 request total", 32'(req_cnt - rc0), 32'd9);

      // Abort during PLAY with 3 queued
      write_note(16'd4, 16'd400);
      wait_req(20, c);
      tick();
      GenBusy_i = 1'b1;
      write_note(16'd1, 16'd11);
      write_note(16'd1, 16'd12);
      write_note(16'd1, 16'd13);
      chk("t4 queued", 32'(Count_o), 32'd3);
      dc0 = done_cnt;
      Abort_i = 1'b1;
      Write_i = 1'b1;
      Duration_ms_i = 16'd9;
      HalfPeriod_us_i = 16'd9;
      #1;
      chk("t4 abort request", 32'(GenRequest_o), 32'd1);
      chk("t4 abort duration", 32'(GenDuration_ms_o), 32'd0);
      chk("t4 abort halfperiod", 32'(GenHalfPeriod_us_o), 32'd1);
      tick();
      Abort_i = 1'b0;
      Write_i = 1'b0;
      chk("t4 count flushed", 32'(Count_o), 32'd0);
      chk("t4 idle", 32'(Busy_o), 32'd0);
      tick();
      rc0 = req_cnt;
      repeat (3) tick();
      GenDone_i = 1'b1;
      GenBusy_i = 1'b0;
      tick();
      GenDone_i = 1'b0;
      repeat (5) tick();
      chk("t4 stray done ignored", 32'(Busy_o), 32'd0);
      chk("t4 no request after abort", 32'(req_cnt - rc0), 32'd0);
      chk("t4 no Done_o", 32'(done_cnt - dc0), 32'd0);

      // Zero-duration entry skipped
      rc0 = req_cnt;
      w = cyc;
      write_note(16'd0, 16'd100);
      write_note(16'd2, 16'd50);
      wait_req(30, c);
      chk("t5 skip latency", 32'(c - w), 32'd6);
      chk("t5 request duration", 32'(GenDuration_ms_o), 32'd2);
      chk("t5 request halfperiod", 32'(GenHalfPeriod_us_o), 32'd50);
      gen_play(3, p);
      wait_done(GAP_CYC + 20, d);
      tick();
      chk("t5 single request", 32'(req_cnt - rc0), 32'd1);

      // Asynchronous reset in the middle of a rest
      rc0 = req_cnt;
      write_note(16'd5, 16'd0);
      repeat (100) tick();
      chk("t6 busy in rest", 32'(Busy_o), 32'd1);
      #2;
      Reset = 1'b0;
      #1;
      chk("t6 rst Busy_o", 32'(Busy_o), 32'd0);
      chk("t6 rst Empty_o", 32'(Empty_o), 32'd1);
      chk("t6 rst GenDuration_ms_o", 32'(GenDuration_ms_o), 32'd0);
      chk("t6 rst GenHalfPeriod_us_o", 32'(GenHalfPeriod_us_o), 32'd0);
      chk("t6 rst Done_o", 32'(Done_o), 32'd0);
      tick();
      Reset = 1'b1;
      repeat (8000) tick();
      chk("t6 no request after reset", 32'(req_cnt - rc0), 32'd0);
      chk("t6 still idle", 32'(Busy_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
